// File: rtl/player_motion.sv
// rtl/player_motion.sv - player sprite position: input sync, game tick, horizontal stepping, jump/gravity FSM
`timescale 1ns/1ps

module player_motion #(
  parameter int CLK_DIV  = 833333,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int V_W      = 6,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 624,
  parameter int X_START  = 320,
  parameter int GROUND_Y = 400,
  parameter int STEP     = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           direction,
  input  logic           move,
  input  logic           jump,
  input  logic           pause,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic           facing,
  output logic           airborne,
  output logic           tick
);

  localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
  localparam int VW1 = V_W + 1;

  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  CNT_ZERO  = '0;
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  localparam logic [XW1-1:0] XE_MIN    = XW1'(X_MIN);
  localparam logic [XW1-1:0] XE_MAX    = XW1'(X_MAX);
  localparam logic [XW1-1:0] XE_STEP   = XW1'(STEP);
  localparam logic [X_W-1:0] XV_MIN    = X_W'(X_MIN);
  localparam logic [X_W-1:0] XV_MAX    = X_W'(X_MAX);
  localparam logic [X_W-1:0] XV_START  = X_W'(X_START);

  localparam logic [YW1-1:0] YE_GROUND = YW1'(GROUND_Y);
  localparam logic [Y_W-1:0] YV_GROUND = Y_W'(GROUND_Y);

  localparam logic [V_W-1:0] V_JUMP    = V_W'(JUMP_V);
  localparam logic [V_W-1:0] V_GRAV    = V_W'(GRAVITY);
  localparam logic [V_W-1:0] V_MAXF    = V_W'(MAX_FALL);
  localparam logic [VW1-1:0] VE_GRAV   = VW1'(GRAVITY);
  localparam logic [VW1-1:0] VE_MAXF   = VW1'(MAX_FALL);

  typedef enum logic [1:0] {
    ST_GROUND  = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2
  } state_e;

  // Two-flop synchronisers, bit order {direction, move, jump, pause}
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic       dir_s;
  logic       move_s;
  logic       jump_s;
  logic       pause_s;

  // Game tick prescaler
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;

  // Jump request capture
  logic jump_prev_q;
  logic jump_edge;
  logic jump_pend_q;
  logic jump_pend_d;

  // A tick that is allowed to change game state
  logic step_en;

  // Horizontal datapath
  logic [X_W-1:0] x_q;
  logic [X_W-1:0] x_d;
  logic           face_q;
  logic           face_d;
  logic [XW1-1:0] x_ext;
  logic [XW1-1:0] x_inc;
  logic [XW1-1:0] x_dec;

  // Vertical datapath and FSM
  state_e         state_q;
  state_e         state_d;
  logic [V_W-1:0] spd_q;
  logic [V_W-1:0] spd_d;
  logic [Y_W-1:0] y_q;
  logic [Y_W-1:0] y_d;
  logic           air_q;
  logic [YW1-1:0] y_ext;
  logic [YW1-1:0] spd_ext;
  logic [YW1-1:0] y_up;
  logic [YW1-1:0] y_down;
  logic [VW1-1:0] spd_inc;

  assign {dir_s, move_s, jump_s, pause_s} = sync2_q;

  // Bring the keyboard-domain levels into the system clock domain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {direction, move, jump, pause};
      sync2_q <= sync1_q;
    end
  end

  // Free-running prescaler; tick is registered so it coincides with the last count
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? CNT_ZERO : cnt_q + CNT_ONE;
  end

  // Prescaler count and registered tick pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  assign jump_edge = jump_s & ~jump_prev_q;
  assign step_en   = tick_q & ~pause_s;

  // Every tick drops the pending request; an edge landing on a tick survives to the next one
  always_comb begin
    jump_pend_d = jump_pend_q | jump_edge;
    if (tick_q) begin
      jump_pend_d = jump_edge;
    end
  end

  // Jump edge detector and pending flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      jump_prev_q <= 1'b0;
      jump_pend_q <= 1'b0;
    end else begin
      jump_prev_q <= jump_s;
      jump_pend_q <= jump_pend_d;
    end
  end

  assign x_ext = {1'b0, x_q};
  assign x_inc = x_ext + XE_STEP;
  assign x_dec = x_ext - XE_STEP;

  // Horizontal step with clamping at both screen edges; one extra bit avoids wrap
  always_comb begin
    x_d    = x_q;
    face_d = face_q;
    if (step_en && move_s) begin
      face_d = dir_s;
      if (dir_s) begin
        x_d = (x_inc > XE_MAX) ? XV_MAX : x_inc[X_W-1:0];
      end else begin
        x_d = (x_ext < XE_MIN + XE_STEP) ? XV_MIN : x_dec[X_W-1:0];
      end
    end
  end

  // Horizontal position and facing registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= XV_START;
      face_q <= 1'b1;
    end else begin
      x_q    <= x_d;
      face_q <= face_d;
    end
  end

  assign y_ext   = {1'b0, y_q};
  assign spd_ext = YW1'(spd_q);
  assign y_up    = y_ext - spd_ext;
  assign y_down  = y_ext + spd_ext;
  assign spd_inc = {1'b0, spd_q} + VE_GRAV;

  // Jump/gravity next-state: rising decelerates to zero, falling accelerates to the cap
  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    y_d     = y_q;
    case (state_q)
      ST_GROUND: begin
        if (step_en && jump_pend_q) begin
          spd_d   = V_JUMP;
          state_d = ST_RISING;
        end
      end
      ST_RISING: begin
        if (step_en) begin
          y_d = (y_ext < spd_ext) ? '0 : y_up[Y_W-1:0];
          if (spd_q > V_GRAV) begin
            spd_d = spd_q - V_GRAV;
          end else begin
            spd_d   = '0;
            state_d = ST_FALLING;
          end
        end
      end
      ST_FALLING: begin
        if (step_en) begin
          if (y_down >= YE_GROUND) begin
            y_d     = YV_GROUND;
            spd_d   = '0;
            state_d = ST_GROUND;
          end else begin
            y_d   = y_down[Y_W-1:0];
            spd_d = (spd_inc > VE_MAXF) ? V_MAXF : spd_inc[V_W-1:0];
          end
        end
      end
      default: begin
        state_d = ST_GROUND;
        spd_d   = '0;
      end
    endcase
  end

  // Vertical state, speed, position and airborne flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_GROUND;
      spd_q   <= '0;
      y_q     <= YV_GROUND;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      spd_q   <= spd_d;
      y_q     <= y_d;
      air_q   <= (state_d != ST_GROUND);
    end
  end

  assign x_pos    = x_q;
  assign y_pos    = y_q;
  assign facing   = face_q;
  assign airborne = air_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - scoreboard bench for player_motion with a behavioural reference model
`timescale 1ns/1ps

module tb_player_motion;

  localparam int CLK_DIV  = 4;
  localparam int X_MIN    = 0;
  localparam int X_MAX    = 624;
  localparam int X_START  = 3;
  localparam int GROUND_Y = 400;
  localparam int STEP     = 2;
  localparam int JUMP_V   = 4;
  localparam int GRAVITY  = 1;
  localparam int MAX_FALL = 12;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       direction = 1'b0;
  logic       move = 1'b0;
  logic       jump = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic       facing;
  logic       airborne;
  logic       tick;

  player_motion #(
    .CLK_DIV (CLK_DIV),
    .X_START (X_START),
    .JUMP_V  (JUMP_V)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .direction (direction),
    .move      (move),
    .jump      (jump),
    .pause     (pause),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .facing    (facing),
    .airborne  (airborne),
    .tick      (tick)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int x;
    int y;
    int face;
    int air;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: raw input history, edge count, signed vertical velocity (negative = up)
  int         m_n, m_x, m_y, m_vy, m_face, m_air, m_pend, exp_tick;
  logic [3:0] h0, h1, h2;
  logic       s_dir, s_move, s_pause, s_jedge;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_n = 0; h0 = '0; h1 = '0; h2 = '0;
      m_x = X_START; m_y = GROUND_Y; m_vy = 0; m_face = 1; m_air = 0; m_pend = 0;
      exp_tick = 0;
      sb_q.delete();
    end else begin
      m_n++;
      s_dir   = h1[3];
      s_move  = h1[2];
      s_pause = h1[0];
      s_jedge = h1[1] && !h2[1];
      if ((m_n - 1) % CLK_DIV == CLK_DIV - 1) begin
        if (!s_pause) begin
          if (s_move) begin
            m_face = s_dir;
            if (s_dir) m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
            else       m_x = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
          end
          if (!m_air) begin
            if (m_pend) begin
              m_air = 1;
              m_vy  = -JUMP_V;
            end
          end else if (m_vy < 0) begin
            m_y  = (m_y + m_vy < 0) ? 0 : m_y + m_vy;
            m_vy = (m_vy + GRAVITY > 0) ? 0 : m_vy + GRAVITY;
          end else if (m_y + m_vy >= GROUND_Y) begin
            m_y = GROUND_Y; m_vy = 0; m_air = 0;
          end else begin
            m_y  = m_y + m_vy;
            m_vy = (m_vy + GRAVITY > MAX_FALL) ? MAX_FALL : m_vy + GRAVITY;
          end
        end
        sb_q.push_back('{m_x, m_y, m_face, m_air});
        m_pend = s_jedge;
      end else begin
        m_pend = m_pend | s_jedge;
      end
      h2 = h1;
      h1 = h0;
      h0 = {direction, move, jump, pause};
      exp_tick = ((m_n % CLK_DIV) == CLK_DIV - 1) ? 1 : 0;
    end
  end

  // Monitor: tick every cycle, full outputs in the cycle after each tick
  logic prev_tick = 1'b0;
  exp_t e;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_tick = 1'b0;
    end else begin
      check("tick", int'(tick), exp_tick);
      if (prev_tick) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("sb_x_pos", int'(x_pos), e.x);
          check("sb_y_pos", int'(y_pos), e.y);
          check("sb_facing", int'(facing), e.face);
          check("sb_airborne", int'(airborne), e.air);
        end
      end
      prev_tick = tick;
    end
  end

  // Wait for the next tick pulse, then return at the negedge after its update
  task automatic next_tick();
    bit seen = 1'b0;
    for (int k = 0; k < 4 * CLK_DIV && !seen; k++) begin
      @(negedge clock);
      if (tick) seen = 1'b1;
    end
    check("tick_seen", int'(seen), 1);
    @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, int'(x_pos), X_START);
    check({tag, "_y"}, int'(y_pos), GROUND_Y);
    check({tag, "_facing"}, int'(facing), 1);
    check({tag, "_airborne"}, int'(airborne), 0);
    check({tag, "_tick"}, int'(tick), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int xs;
    int traj[10];
    traj = '{400, 396, 393, 391, 390, 390, 391, 393, 396, 400};

    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset_n = 1'b1;

    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (tick) cnt++;
    end
    check("tick_count_40", cnt, 10);

    // Move raised one cycle before a tick is not seen by that tick
    next_tick();
    @(negedge clock);
    @(negedge clock);
    direction = 1'b1;
    move = 1'b1;
    next_tick();
    check("sync_no_move", int'(x_pos), 3);
    next_tick();
    check("sync_moved", int'(x_pos), 5);

    // Right clamp from an odd position
    for (int k = 0; k < 400 && x_pos != 10'd623; k++) next_tick();
    check("right_623", int'(x_pos), 623);
    next_tick();
    check("right_clamp1", int'(x_pos), 624);
    next_tick();
    check("right_clamp2", int'(x_pos), 624);
    check("right_facing", int'(facing), 1);
    move = 1'b0;

    // Reset mid-jump acts immediately
    jump = 1'b1;
    next_tick();
    next_tick();
    jump = 1'b0;
    check("prereset_air", int'(airborne), 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Left clamp from x=3
    next_tick();
    direction = 1'b0;
    move = 1'b1;
    next_tick();
    check("left_1", int'(x_pos), 1);
    check("left_facing", int'(facing), 0);
    next_tick();
    check("left_0a", int'(x_pos), 0);
    next_tick();
    check("left_0b", int'(x_pos), 0);
    move = 1'b0;

    // Full trajectory with jump held high
    next_tick();
    jump = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_tick();
      check("traj_y", int'(y_pos), traj[i]);
      check("traj_air", int'(airborne), (i < 9) ? 1 : 0);
    end
    next_tick();
    check("held_no_retrig_y", int'(y_pos), 400);
    check("held_no_retrig_air", int'(airborne), 0);
    jump = 1'b0;

    // Second press while airborne is ignored
    next_tick();
    jump = 1'b1;
    next_tick();
    jump = 1'b0;
    next_tick();
    next_tick();
    check("dbl_y393", int'(y_pos), 393);
    jump = 1'b1;
    next_tick();
    jump = 1'b0;
    for (int k = 0; k < 12 && airborne; k++) next_tick();
    check("dbl_land_y", int'(y_pos), 400);
    next_tick();
    check("dbl_no_rejump_air", int'(airborne), 0);
    check("dbl_no_rejump_y", int'(y_pos), 400);

    // Pause mid-jump freezes state; a press during pause is dropped
    jump = 1'b1;
    next_tick();
    jump = 1'b0;
    next_tick();
    next_tick();
    check("pause_start_y", int'(y_pos), 393);
    pause = 1'b1;
    xs = int'(x_pos);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) jump = 1'b1;
      next_tick();
      jump = 1'b0;
      check("pause_y", int'(y_pos), 393);
      check("pause_x", int'(x_pos), xs);
      check("pause_air", int'(airborne), 1);
    end
    pause = 1'b0;
    for (int i = 3; i < 10; i++) begin
      next_tick();
      check("resume_y", int'(y_pos), traj[i]);
    end
    check("resume_land_air", int'(airborne), 0);

    // Randomised soak against the model
    for (int i = 0; i < 300; i++) begin
      direction = 1'($urandom_range(0, 1));
      move      = ($urandom_range(0, 3) != 0);
      jump      = ($urandom_range(0, 5) == 0);
      pause     = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clock);
    end
    direction = 1'b0;
    move = 1'b0;
    jump = 1'b0;
    pause = 1'b0;
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
